alu_issue_controller: RTL and testbench
=======================================

# alu_issue_controller

Multi-cycle issue and writeback sequencer that sits in front of the processor's ALU. It accepts one 32-bit instruction word per handshake, reads the two source registers from the register file, and drives the ALU's funct, operand and immediate inputs. It then captures the combinational ALU result and writes it back to the destination register, so it is the producer of the ALU's inputs and the consumer of its output.

## Interface
Parameters:
- `DATA_W`, 32: operand/result width; must match ALU.
- `REG_AW`, 5: register-file address width.
- `CNT_W`, 16: width of retired-instruction counter.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction word offered.
- `instr`  in  32  instruction: [31:26] funct, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
- `instr_ready`  out  1  controller can accept; transfer when `instr_valid && instr_ready`.
- `rf_rs_addr`, `rf_rt_addr`  out  REG_AW  register-file read addresses.
- `rf_rs_data`, `rf_rt_data`  in  DATA_W  register-file read data (combinational read).
- `alu_funct`  out  6  ALU operation code.
- `alu_rs`, `alu_rt`, `alu_imm`  out  DATA_W  ALU operand 1, operand 2, immediate.
- `alu_result`  in  DATA_W  combinational ALU result.
- `rf_we`  out  1  one-cycle write strobe.
- `rf_wa`  out  REG_AW  write address.
- `rf_wd`  out  DATA_W  write data.
- `illegal`  out  1  one-cycle pulse: rejected instruction.
- `retired`  out  CNT_W  count of `rf_we` pulses, wraps modulo 2^CNT_W.

## Operation
- Funct codes: ADD=0, ADDI=1, SUB=2, SUBI=3, AND=4, ANDI=5, OR=6, ORI=7, XOR=8, NOR=9, NOT=10, SLT=11, SLE=12, SGT=13, SGE=14, EQ=15, NEQ=16, MULT=17, DIV=18. Funct > 18 is illegal.
- Immediate forms (1, 3, 5, 7) write to `rt`. All other forms write to `rd`.
- `alu_imm` = imm sign-extended to DATA_W (imm=16'hFFFF gives 32'hFFFF_FFFF).
- Destination register 0: writeback suppressed. `rf_we` stays 0 and `retired` does not increment. This is not illegal.
- FSM states:
  - IDLE: `instr_ready`=1. On handshake, latch `instr` and go to READ.
  - READ: latch `rf_rs_data` and `rf_rt_data` into operand registers; go to EXEC.
  - EXEC: operand registers drive ALU; latch `alu_result`; go to WB.
  - WB: pulse `rf_we`, or pulse `illegal` if rejected; return to IDLE.
- Illegal funct: READ and EXEC still sequence. In WB, `illegal`=1 and `rf_we`=0.
- `instr` while not ready is ignored; `instr_valid` may drop freely.

## Timing
- Cycle 0 = handshake edge. READ in cycle 1, EXEC in cycle 2, WB in cycle 3 (`rf_we`/`illegal` high for exactly that cycle). `instr_ready` is high again in cycle 4.
- Throughput: one instruction per 4 cycles. Back-to-back handshake at cycle 4 is allowed.
- `instr_ready` is registered. It is low only during READ/EXEC/WB.
- `rf_rs_addr` and `rf_rt_addr` are driven from the latched instruction. They are held from cycle 1 until the next handshake.
- `alu_*` outputs are registered, stable in EXEC and held until the next READ.
- Reset values: `instr_ready`=0 (rises on first edge after release), `rf_we`=0, `illegal`=0, `retired`=0. All address, data and ALU outputs are 0. FSM resets to IDLE.
- Reset asserted mid-instruction aborts it immediately. No writeback occurs and no pulse is issued.
- `retired` wraps from 2^CNT_W−1 to 0.

## Configuration
- `ALU_DIVZERO_TRAP_EN` defined: DIV with operand 2 == 0 is rejected. In WB, `illegal`=1, `rf_we`=0 and `retired` is unchanged.
- Not defined: DIV by zero is written back with whatever `alu_result` presents, and `retired` increments.

## Test plan
- ADD r3=r1+r2 with r1=5, r2=7: handshake at cycle 0 → cycle 3 `rf_we`=1, `rf_wa`=3, `rf_wd`=12, `retired`=1; `instr_ready`=1 in cycle 4.
- ADDI rt=4, rs=1 (r1=10), imm=16'hFFFF → `alu_imm`=32'hFFFF_FFFF, `rf_wa`=4, `rf_wd`=9.
- funct=6'd40 → cycle 3 `illegal`=1, `rf_we`=0, `retired` unchanged; SUB with rd=0 → no write, no `illegal`.
- Hold `instr_valid`=1 with 3 distinct instructions → handshakes at cycles 0/4/8; writes at cycles 3/7/11 in order.
- Assert `reset_n`=0 during EXEC → no `rf_we`; all outputs 0; `instr_ready`=1 one edge after release.
- DIV r5=r1/r2 with r2=0: with `ALU_DIVZERO_TRAP_EN`, `illegal`=1 and `rf_we`=0; without it, `rf_we`=1 at `rf_wa`=5.

Source files
------------

// File: rtl/alu_issue_controller_if.sv
// Issue/writeback bus between alu_issue_controller and its environment.
// master = controller side, slave = instruction source, regfile and ALU.
interface alu_issue_controller_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              instr_valid;
   logic [31:0]       instr;
   logic              instr_ready;
   logic [REG_AW-1:0] rf_rs_addr;
   logic [REG_AW-1:0] rf_rt_addr;
   logic [DATA_W-1:0] rf_rs_data;
   logic [DATA_W-1:0] rf_rt_data;
   logic [5:0]        alu_funct;
   logic [DATA_W-1:0] alu_rs;
   logic [DATA_W-1:0] alu_rt;
   logic [DATA_W-1:0] alu_imm;
   logic [DATA_W-1:0] alu_result;
   logic              rf_we;
   logic [REG_AW-1:0] rf_wa;
   logic [DATA_W-1:0] rf_wd;
   logic              illegal;
   logic [CNT_W-1:0]  retired;

   modport master (
      input  instr_valid, instr,
      output instr_ready,
      output rf_rs_addr, rf_rt_addr,
      input  rf_rs_data, rf_rt_data,
      output alu_funct, alu_rs, alu_rt, alu_imm,
      input  alu_result,
      output rf_we, rf_wa, rf_wd,
      output illegal, retired
   );

   modport slave (
      output instr_valid, instr,
      input  instr_ready,
      input  rf_rs_addr, rf_rt_addr,
      output rf_rs_data, rf_rt_data,
      input  alu_funct, alu_rs, alu_rt, alu_imm,
      output alu_result,
      input  rf_we, rf_wa, rf_wd,
      input  illegal, retired
   );
endinterface

// File: rtl/alu_issue_controller.sv
// Four-state issue/writeback sequencer in front of the ALU.
// ALU_DIVZERO_TRAP_EN: reject DIV whose second operand is zero.
module alu_issue_controller #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   alu_issue_controller_if.master bus
);

   localparam logic [5:0] F_ADDI = 6'd1;
   localparam logic [5:0] F_SUBI = 6'd3;
   localparam logic [5:0] F_ANDI = 6'd5;
   localparam logic [5:0] F_ORI  = 6'd7;
   localparam logic [5:0] F_DIV  = 6'd18;
   localparam logic [5:0] F_LAST = 6'd18;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      EXEC,
      WB
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [31:0]       instr_q;
   logic              ready_q;
   logic [5:0]        funct_q;
   logic [DATA_W-1:0] rs_q;
   logic [DATA_W-1:0] rt_q;
   logic [DATA_W-1:0] imm_q;
   logic              we_q;
   logic [REG_AW-1:0] wa_q;
   logic [DATA_W-1:0] wd_q;
   logic              ill_q;
   logic [CNT_W-1:0]  ret_q;

   logic [5:0]        funct;
   logic              hs;
   logic              imm_form;
   logic              bad_funct;
   logic              div_zero;
   logic              reject;
   logic              wr_en;
   logic [REG_AW-1:0] dest;
   logic [DATA_W-1:0] imm_ext;

   assign funct   = instr_q[31:26];
   assign hs      = (state_q == IDLE) && ready_q && bus.instr_valid;
   assign imm_ext = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};

   always_comb begin
      imm_form  = 1'b0;
      bad_funct = 1'b0;
      unique case (1'b1)
         (funct > F_LAST): bad_funct = 1'b1;
         (funct inside {F_ADDI, F_SUBI, F_ANDI, F_ORI}): imm_form = 1'b1;
         default: ;
      endcase
   end

`ifdef ALU_DIVZERO_TRAP_EN
   assign div_zero = (funct == F_DIV) && (rt_q == '0);
`else
   assign div_zero = 1'b0;
`endif

   assign dest   = imm_form ? REG_AW'(instr_q[20:16])
                            : REG_AW'(instr_q[15:11]);
   assign reject = bad_funct || div_zero;
   // r0 is hardwired: suppressed, but not an error
   assign wr_en  = !reject && (dest != '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (hs) state_d = READ;
         READ: state_d = EXEC;
         EXEC: state_d = WB;
         WB:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         instr_q <= '0;
         ready_q <= 1'b0;
         funct_q <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         imm_q   <= '0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         ill_q   <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
         we_q    <= 1'b0;
         ill_q   <= 1'b0;
         if (hs) begin
            instr_q <= bus.instr;
         end
         if (state_q == READ) begin
            rs_q    <= bus.rf_rs_data;
            rt_q    <= bus.rf_rt_data;
            funct_q <= funct;
            imm_q   <= imm_ext;
         end
         // strobes and counter move together so retired is current in WB
         if (state_q == EXEC) begin
            we_q  <= wr_en;
            ill_q <= reject;
            wa_q  <= dest;
            wd_q  <= bus.alu_result;
            if (wr_en) begin
               ret_q <= ret_q + CNT_W'(1);
            end
         end
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.rf_rs_addr  = REG_AW'(instr_q[25:21]);
   assign bus.rf_rt_addr  = REG_AW'(instr_q[20:16]);
   assign bus.alu_funct   = funct_q;
   assign bus.alu_rs      = rs_q;
   assign bus.alu_rt      = rt_q;
   assign bus.alu_imm     = imm_q;
   assign bus.rf_we       = we_q;
   assign bus.rf_wa       = wa_q;
   assign bus.rf_wd       = wd_q;
   assign bus.illegal     = ill_q;
   assign bus.retired     = ret_q;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Scoreboard bench for alu_issue_controller with a register file
// and ALU model on the slave side of the bus.
module tb_alu_issue_controller;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   alu_issue_controller_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();

   alu_issue_controller #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int          due;
      bit          we;
      bit          ill;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [15:0] ret;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] rf[32];
   logic [31:0] ref_rf[32];
   logic [15:0] ref_ret;

   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'd0;
      if (i == 1) return 32'd5;
      if (i == 2) return 32'd7;
      return (32'(i) * 32'h0101_0101) ^ 32'h5A;
   endfunction

   function automatic logic [31:0] alu_f(input logic [5:0] f,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
      case (f)
         6'd0:  return a + b;
         6'd1:  return a + i;
         6'd2:  return a - b;
         6'd3:  return a - i;
         6'd4:  return a & b;
         6'd5:  return a & i;
         6'd6:  return a | b;
         6'd7:  return a | i;
         6'd8:  return a ^ b;
         6'd9:  return ~(a | b);
         6'd10: return ~a;
         6'd11: return {31'b0, $signed(a) <  $signed(b)};
         6'd12: return {31'b0, $signed(a) <= $signed(b)};
         6'd13: return {31'b0, $signed(a) >  $signed(b)};
         6'd14: return {31'b0, $signed(a) >= $signed(b)};
         6'd15: return {31'b0, a == b};
         6'd16: return {31'b0, a != b};
         6'd17: return a * b;
         6'd18: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] enc_r(input int f, input int rs,
      input int rt, input int rd);
      return {6'(f), 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] enc_i(input int f, input int rs,
      input int rt, input logic [15:0] imm);
      return {6'(f), 5'(rs), 5'(rt), imm};
   endfunction

   assign bus.rf_rs_data = rf[bus.rf_rs_addr];
   assign bus.rf_rt_data = rf[bus.rf_rt_addr];

   always_comb begin
      bus.alu_result = alu_f(bus.alu_funct, bus.alu_rs, bus.alu_rt, bus.alu_imm);
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = init_val(i);
      forever begin
         @(posedge clock);
         if (bus.rf_we && bus.rf_wa != 5'd0) rf[bus.rf_wa] = bus.rf_wd;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] w, input int due);
      exp_t        e;
      logic [5:0]  f;
      logic [4:0]  dst;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] im;
      bit          ill;
      f   = w[31:26];
      a   = ref_rf[w[25:21]];
      b   = ref_rf[w[20:16]];
      im  = {{16{w[15]}}, w[15:0]};
      dst = (f inside {6'd1, 6'd3, 6'd5, 6'd7}) ? w[20:16] : w[15:11];
      ill = (f > 6'd18);
`ifdef ALU_DIVZERO_TRAP_EN
      if (f == 6'd18 && b == 32'd0) ill = 1'b1;
`endif
      e.due = due;
      e.ill = ill;
      e.we  = !ill && (dst != 5'd0);
      e.wa  = dst;
      e.wd  = alu_f(f, a, b, im);
      if (e.we) begin
         ref_rf[dst] = e.wd;
         ref_ret = ref_ret + 16'd1;
      end
      e.ret = ref_ret;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [31:0] w, output int pc);
      int n;
      @(negedge clock);
      bus.instr_valid = 1'b1;
      bus.instr = w;
      n = 0;
      while (!bus.instr_ready && n < 16) begin
         @(negedge clock);
         n++;
      end
      pc = cyc;
      chk("hs_ready", {31'b0, bus.instr_ready}, 32'd1);
      if (bus.instr_ready) push(w, cyc + 3);
   endtask

   task automatic idle();
      @(negedge clock);
      bus.instr_valid = 1'b0;
      bus.instr = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clock) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk("wb_we",  {31'b0, bus.rf_we},   {31'b0, e.we});
         chk("wb_ill", {31'b0, bus.illegal}, {31'b0, e.ill});
         if (e.we) begin
            chk("wb_wa", {27'b0, bus.rf_wa}, {27'b0, e.wa});
            chk("wb_wd", bus.rf_wd, e.wd);
         end
         chk("wb_ret", {16'b0, bus.retired}, {16'b0, e.ret});
      end else if (bus.rf_we || bus.illegal) begin
         chk("spurious", {30'b0, bus.rf_we, bus.illegal}, 32'd0);
      end
   end

   initial begin
      int pc, p1, p2, p3;
      bus.instr_valid = 1'b0;
      bus.instr = 32'd0;
      ref_ret = 16'd0;
      for (int i = 0; i < 32; i++) ref_rf[i] = init_val(i);

      repeat (3) @(negedge clock);
      chk("rst_ready",   {31'b0, bus.instr_ready}, 32'd0);
      chk("rst_we",      {31'b0, bus.rf_we},       32'd0);
      chk("rst_retired", {16'b0, bus.retired},     32'd0);
      chk("rst_alu_rs",  bus.alu_rs,               32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rel_ready", {31'b0, bus.instr_ready}, 32'd1);

      // ADD r3 = r1 + r2 (5 + 7)
      issue(enc_r(0, 1, 2, 3), pc);
      idle();
      repeat (2) @(negedge clock);
      chk("add_we",  {31'b0, bus.rf_we},       32'd1);
      chk("add_wa",  {27'b0, bus.rf_wa},       32'd3);
      chk("add_wd",  bus.rf_wd,                32'd12);
      chk("add_ret", {16'b0, bus.retired},     32'd1);
      chk("add_busy", {31'b0, bus.instr_ready}, 32'd0);
      @(negedge clock);
      chk("add_ready", {31'b0, bus.instr_ready}, 32'd1);

      // r1 = 10, then ADDI r4 = r1 + 0xFFFF
      issue(enc_i(1, 0, 1, 16'd10), pc);
      issue(enc_i(1, 1, 4, 16'hFFFF), pc);
      idle();
      repeat (2) @(negedge clock);
      chk("addi_imm", bus.alu_imm,          32'hFFFF_FFFF);
      chk("addi_wa",  {27'b0, bus.rf_wa},   32'd4);
      chk("addi_wd",  bus.rf_wd,            32'd9);
      chk("addi_rs",  {27'b0, bus.rf_rs_addr}, 32'd1);

      // illegal funct, then SUB into r0
      issue(enc_r(40, 1, 2, 6), pc);
      idle();
      repeat (2) @(negedge clock);
      chk("ill_pulse", {31'b0, bus.illegal}, 32'd1);
      chk("ill_we",    {31'b0, bus.rf_we},   32'd0);
      chk("ill_ret",   {16'b0, bus.retired}, 32'd3);
      issue(enc_r(2, 1, 2, 0), pc);
      idle();
      repeat (2) @(negedge clock);
      chk("r0_we",  {31'b0, bus.rf_we},   32'd0);
      chk("r0_ill", {31'b0, bus.illegal}, 32'd0);
      chk("r0_ret", {16'b0, bus.retired}, 32'd3);

      // back-to-back with valid held high
      issue(enc_r(8, 1, 2, 6), p1);
      issue(enc_r(11, 4, 3, 7), p2);
      issue(enc_r(17, 3, 4, 8), p3);
      idle();
      chk("b2b_gap1", 32'(p2 - p1), 32'd4);
      chk("b2b_gap2", 32'(p3 - p2), 32'd4);
      drain();

      // reset during EXEC aborts the instruction
      issue(enc_r(0, 1, 2, 9), pc);
      idle();
      @(negedge clock);
      reset_n = 1'b0;
      sb.delete();
      #1;
      chk("abort_ready", {31'b0, bus.instr_ready}, 32'd0);
      chk("abort_we",    {31'b0, bus.rf_we},       32'd0);
      chk("abort_ret",   {16'b0, bus.retired},     32'd0);
      chk("abort_funct", {26'b0, bus.alu_funct},   32'd0);
      chk("abort_rsa",   {27'b0, bus.rf_rs_addr},  32'd0);
      chk("abort_wd",    bus.rf_wd,                32'd0);
      ref_ret = 16'd0;
      for (int i = 0; i < 32; i++) ref_rf[i] = rf[i];
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("abort_rel_ready", {31'b0, bus.instr_ready}, 32'd1);
      chk("abort_r9", rf[9], init_val(9));

      // r2 = 0, then DIV r5 = r1 / r2
      issue(enc_r(4, 0, 0, 2), pc);
      issue(enc_r(18, 1, 2, 5), pc);
      idle();
      repeat (2) @(negedge clock);
`ifdef ALU_DIVZERO_TRAP_EN
      chk("divz_ill", {31'b0, bus.illegal}, 32'd1);
      chk("divz_we",  {31'b0, bus.rf_we},   32'd0);
      chk("divz_ret", {16'b0, bus.retired}, 32'd1);
`else
      chk("divz_ill", {31'b0, bus.illegal}, 32'd0);
      chk("divz_we",  {31'b0, bus.rf_we},   32'd1);
      chk("divz_wa",  {27'b0, bus.rf_wa},   32'd5);
      chk("divz_ret", {16'b0, bus.retired}, 32'd2);
`endif

      for (int k = 0; k < 40; k++) begin
         logic [31:0] w;
         w = {6'($urandom_range(0, 21)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 16'($urandom)};
         issue(w, pc);
         if ($urandom_range(0, 2) == 0) idle();
      end
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
